// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | cpu_ctrl_pkg : shared control types, opcodes and ALU selects      |
// | Revision     : 1.0                                                |
// +-------------------------------------------------------------------+
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6
  } state_e;

  localparam logic [4:0] c_op_add  = 5'b00011;
  localparam logic [4:0] c_op_sub  = 5'b00100;
  localparam logic [4:0] c_op_and  = 5'b00101;
  localparam logic [4:0] c_op_or   = 5'b00110;
  localparam logic [4:0] c_op_ror  = 5'b00111;
  localparam logic [4:0] c_op_rol  = 5'b01000;
  localparam logic [4:0] c_op_shr  = 5'b01001;
  localparam logic [4:0] c_op_shra = 5'b01010;
  localparam logic [4:0] c_op_shl  = 5'b01011;

  localparam logic [3:0] c_alu_add  = 4'd0;
  localparam logic [3:0] c_alu_sub  = 4'd1;
  localparam logic [3:0] c_alu_and  = 4'd2;
  localparam logic [3:0] c_alu_or   = 4'd3;
  localparam logic [3:0] c_alu_shr  = 4'd4;
  localparam logic [3:0] c_alu_shra = 4'd5;
  localparam logic [3:0] c_alu_shl  = 4'd6;
  localparam logic [3:0] c_alu_ror  = 4'd7;
  localparam logic [3:0] c_alu_rol  = 4'd8;

  typedef struct packed {
    logic       valid;
    logic [3:0] sel;
  } alu_dec_t;

  function automatic alu_dec_t decode_op(input logic [4:0] op);
    alu_dec_t d;
    d.valid = 1'b1;
    d.sel   = c_alu_add;
    case (op)
      c_op_add:  d.sel = c_alu_add;
      c_op_sub:  d.sel = c_alu_sub;
      c_op_and:  d.sel = c_alu_and;
      c_op_or:   d.sel = c_alu_or;
      c_op_shr:  d.sel = c_alu_shr;
      c_op_shra: d.sel = c_alu_shra;
      c_op_shl:  d.sel = c_alu_shl;
      c_op_ror:  d.sel = c_alu_ror;
      c_op_rol:  d.sel = c_alu_rol;
      default:   d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_onehot_dec.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | reg_onehot_dec : 4-bit register index + enable to one-hot vector  |
// | Revision       : 1.0                                              |
// +-------------------------------------------------------------------+
module reg_onehot_dec #(
  parameter int NREGS = 16
) (
  input  logic [3:0]       i_idx,
  input  logic             i_en,
  output logic [NREGS-1:0] o_onehot
);

  // Indices beyond NREGS-1 simply select nothing.
  for (genvar i = 0; i < NREGS; i++) begin : g_bit
    assign o_onehot[i] = i_en && (i_idx == 4'(i));
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | alu_sequencer : T-state control FSM for reg-reg ALU instructions  |
// | Revision      : 1.0                                               |
// +-------------------------------------------------------------------+
module alu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             mem_ready,
  input  logic [4:0]       ir_op,
  input  logic [3:0]       ir_ra,
  input  logic [3:0]       ir_rb,
  input  logic [3:0]       ir_rc,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             pc_out,
  output logic             pc_in,
  output logic             inc_pc,
  output logic             mar_in,
  output logic             mem_read,
  output logic             mdr_in,
  output logic             mdr_out,
  output logic             ir_in,
  output logic             y_in,
  output logic             z_in,
  output logic             zlo_out,
  output logic [NREGS-1:0] r_out,
  output logic [NREGS-1:0] r_in,
  output logic [3:0]       alu_sel
);

  state_e     state_q, state_d;
  logic [3:0] alu_sel_q, alu_sel_d;
  logic       illegal_q, illegal_d;
  alu_dec_t   w_dec;

  logic             w_en_rb, w_en_rc, w_en_ra;
  logic [NREGS-1:0] w_r_out_rb, w_r_out_rc, w_r_in_ra;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= ST_IDLE;
      alu_sel_q <= c_alu_add;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_sel_q <= alu_sel_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_sel_d = alu_sel_q;
    illegal_d = 1'b0;
    w_dec     = decode_op(ir_op);
    case (state_q)
      ST_IDLE: if (start) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (mem_ready) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        // Unsupported opcodes abort here; the flag gives the IDLE-entry pulse.
        if (w_dec.valid) begin
          alu_sel_d = w_dec.sel;
          state_d   = ST_T4;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = start ? ST_T0 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_out   = 1'b0;
    pc_in    = 1'b0;
    inc_pc   = 1'b0;
    mar_in   = 1'b0;
    mem_read = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    zlo_out  = 1'b0;
    case (state_q)
      ST_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      ST_T1: begin
        zlo_out  = 1'b1;
        pc_in    = 1'b1;
        mem_read = 1'b1;
        mdr_in   = 1'b1;
      end
      ST_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      ST_T3:   y_in = 1'b1;
      ST_T4:   z_in = 1'b1;
      ST_T5:   zlo_out = 1'b1;
      default: ;
    endcase
  end

  assign w_en_rb = (state_q == ST_T3);
  assign w_en_rc = (state_q == ST_T4);
  assign w_en_ra = (state_q == ST_T5);

  reg_onehot_dec #(.NREGS(NREGS)) u_dec_rb (.i_idx(ir_rb), .i_en(w_en_rb), .o_onehot(w_r_out_rb));
  reg_onehot_dec #(.NREGS(NREGS)) u_dec_rc (.i_idx(ir_rc), .i_en(w_en_rc), .o_onehot(w_r_out_rc));
  reg_onehot_dec #(.NREGS(NREGS)) u_dec_ra (.i_idx(ir_ra), .i_en(w_en_ra), .o_onehot(w_r_in_ra));

  assign r_out   = w_r_out_rb | w_r_out_rc;
  assign r_in    = w_r_in_ra;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_T5) | illegal_q;
  assign illegal = illegal_q;
  assign alu_sel = alu_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_alu_sequencer : scoreboard bench for alu_sequencer             |
// | Revision         : 1.0                                            |
// +-------------------------------------------------------------------+
module tb_alu_sequencer;

  localparam int NREGS  = 16;
  localparam int S_IDLE = 0;
  localparam int S_T0   = 1;
  localparam int S_T1   = 2;
  localparam int S_T2   = 3;
  localparam int S_T3   = 4;
  localparam int S_T4   = 5;
  localparam int S_T5   = 6;

  logic             clock = 1'b0;
  logic             clear_n, start, mem_ready;
  logic [4:0]       ir_op;
  logic [3:0]       ir_ra, ir_rb, ir_rc;
  logic             busy, done, illegal;
  logic             pc_out, pc_in, inc_pc, mar_in, mem_read, mdr_in, mdr_out, ir_in;
  logic             y_in, z_in, zlo_out;
  logic [NREGS-1:0] r_out, r_in;
  logic [3:0]       alu_sel;

  always #5 clock = ~clock;

  alu_sequencer #(.NREGS(NREGS)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .mem_ready(mem_ready),
    .ir_op(ir_op), .ir_ra(ir_ra), .ir_rb(ir_rb), .ir_rc(ir_rc),
    .busy(busy), .done(done), .illegal(illegal),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
    .mem_read(mem_read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out),
    .r_out(r_out), .r_in(r_in), .alu_sel(alu_sel)
  );

  logic [49:0] dut_vec;
  assign dut_vec = {busy, done, illegal, pc_out, pc_in, inc_pc, mar_in, mem_read,
                    mdr_in, mdr_out, ir_in, y_in, z_in, zlo_out, r_out, r_in, alu_sel};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  int          m_st  = S_IDLE;
  logic        m_ill = 1'b0;
  logic [3:0]  m_alu = 4'd0;
  logic [49:0] exp_q[$];
  string       tag_q[$];

  int cyc = 0, done_cnt = 0, ill_cnt = 0, last_done = 0, prev_done = 0;

  function automatic logic [3:0] exp_sel(input logic [4:0] op, output logic ok);
    ok = 1'b1;
    case (op)
      5'b00011: return 4'd0;
      5'b00100: return 4'd1;
      5'b00101: return 4'd2;
      5'b00110: return 4'd3;
      5'b01001: return 4'd4;
      5'b01010: return 4'd5;
      5'b01011: return 4'd6;
      5'b00111: return 4'd7;
      5'b01000: return 4'd8;
      default: begin ok = 1'b0; return 4'd0; end
    endcase
  endfunction

  function automatic logic [49:0] exp_vec(input int st, input logic ill, input logic [3:0] alu,
                                          input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [3:0] rc);
    logic b, d, po, pi, ip, mi, mr, mdi, mdo, iri, yi, zi, zo;
    logic [15:0] ro, ri;
    {po, pi, ip, mi, mr, mdi, mdo, iri, yi, zi, zo} = '0;
    ro = '0;
    ri = '0;
    b  = (st != S_IDLE);
    d  = (st == S_T5) || ill;
    case (st)
      S_T0: begin po = 1; mi = 1; ip = 1; zi = 1; end
      S_T1: begin zo = 1; pi = 1; mr = 1; mdi = 1; end
      S_T2: begin mdo = 1; iri = 1; end
      S_T3: begin yi = 1; ro = 16'h1 << rb; end
      S_T4: begin zi = 1; ro = 16'h1 << rc; end
      S_T5: begin zo = 1; ri = 16'h1 << ra; end
      default: ;
    endcase
    return {b, d, ill, po, pi, ip, mi, mr, mdi, mdo, iri, yi, zi, zo, ro, ri, alu};
  endfunction

  always @(negedge clock) begin
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      prev_done = last_done;
      last_done = cyc;
    end
    if (done === 1'b1 && illegal === 1'b1) ill_cnt++;
    if (exp_q.size() > 0) check_eq(tag_q.pop_front(), {14'b0, dut_vec}, {14'b0, exp_q.pop_front()});
  end

  task automatic drive(input logic s, input logic mr, input logic rn, input string tag);
    int nxt;
    logic ill_n, ok;
    logic [3:0] sel;
    @(negedge clock);
    #1;
    start     = s;
    mem_ready = mr;
    clear_n   = rn;
    ill_n     = 1'b0;
    nxt       = m_st;
    if (!rn) begin
      nxt   = S_IDLE;
      m_alu = 4'd0;
    end else begin
      case (m_st)
        S_IDLE: nxt = s ? S_T0 : S_IDLE;
        S_T0:   nxt = S_T1;
        S_T1:   nxt = mr ? S_T2 : S_T1;
        S_T2:   nxt = S_T3;
        S_T3: begin
          sel = exp_sel(ir_op, ok);
          if (ok) begin m_alu = sel; nxt = S_T4; end
          else begin nxt = S_IDLE; ill_n = 1'b1; end
        end
        S_T4:   nxt = S_T5;
        S_T5:   nxt = s ? S_T0 : S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
    m_st  = nxt;
    m_ill = ill_n;
    exp_q.push_back(exp_vec(m_st, m_ill, m_alu, ir_ra, ir_rb, ir_rc));
    tag_q.push_back(tag);
  endtask

  task automatic flush();
    for (int k = 0; k < 10; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
      #1;
    end
    check_eq("flush", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rc, input int waits, input string tag,
                           output int t0);
    int w;
    ir_op = op; ir_ra = ra; ir_rb = rb; ir_rc = rc;
    drive(1'b1, 1'b1, 1'b1, {tag, "_go"});
    t0 = cyc;
    w  = waits;
    for (int k = 0; k < 20 && m_st != S_IDLE; k++) begin
      if (m_st == S_T1 && w > 0) begin
        w--;
        drive(1'b0, 1'b0, 1'b1, $sformatf("%s_c%0d", tag, k));
      end else begin
        drive(1'b0, 1'b1, 1'b1, $sformatf("%s_c%0d", tag, k));
      end
    end
    drive(1'b0, 1'b1, 1'b1, {tag, "_idle"});
    flush();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d0, i0;
    clear_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
    ir_op = '0; ir_ra = '0; ir_rb = '0; ir_rc = '0;
    repeat (2) @(negedge clock);
    check_eq("rst_low", {14'b0, dut_vec}, 64'd0);
    repeat (3) drive(1'b0, 1'b0, 1'b1, "rst_idle");
    flush();

    // AND, zero wait
    d0 = done_cnt;
    run_instr(5'b00101, 4'd3, 4'd1, 4'd2, 0, "and0", t0);
    check_eq("and0_latency", 64'(last_done - t0), 64'd6);
    check_eq("and0_done_cnt", 64'(done_cnt - d0), 64'd1);
    check_eq("and0_alu_sel", {60'b0, alu_sel}, 64'd2);

    // AND, three wait cycles
    run_instr(5'b00101, 4'd3, 4'd1, 4'd2, 3, "and3", t0);
    check_eq("and3_latency", 64'(last_done - t0), 64'd9);

    // Illegal opcode
    d0 = done_cnt; i0 = ill_cnt;
    run_instr(5'b11111, 4'd5, 4'd6, 4'd7, 0, "ill", t0);
    check_eq("ill_done_cnt", 64'(done_cnt - d0), 64'd1);
    check_eq("ill_pulse_cnt", 64'(ill_cnt - i0), 64'd1);

    // Two back-to-back OR instructions
    ir_op = 5'b00110; ir_ra = 4'd9; ir_rb = 4'd10; ir_rc = 4'd15;
    d0 = done_cnt;
    repeat (7) drive(1'b1, 1'b1, 1'b1, "b2b_hold");
    for (int k = 0; k < 20 && m_st != S_IDLE; k++) drive(1'b0, 1'b1, 1'b1, "b2b_tail");
    drive(1'b0, 1'b1, 1'b1, "b2b_idle");
    flush();
    check_eq("b2b_done_cnt", 64'(done_cnt - d0), 64'd2);
    check_eq("b2b_spacing", 64'(last_done - prev_done), 64'd6);

    // Reset asserted during T4
    ir_op = 5'b01011; ir_ra = 4'd4; ir_rb = 4'd8; ir_rc = 4'd12;
    d0 = done_cnt;
    drive(1'b1, 1'b1, 1'b1, "rst4_go");
    repeat (4) drive(1'b0, 1'b1, 1'b1, "rst4_run");
    flush();
    #2 clear_n = 1'b0;
    #1 check_eq("rst4_async", {14'b0, dut_vec}, 64'd0);
    m_st = S_IDLE; m_ill = 1'b0; m_alu = 4'd0;
    drive(1'b0, 1'b1, 1'b0, "rst4_hold");
    drive(1'b0, 1'b1, 1'b1, "rst4_rel");
    drive(1'b0, 1'b1, 1'b1, "rst4_idle");
    flush();
    check_eq("rst4_no_done", 64'(done_cnt - d0), 64'd0);

    // SUB after reset to show alu_sel updates again
    run_instr(5'b00100, 4'd0, 4'd15, 4'd14, 1, "sub", t0);
    check_eq("sub_latency", 64'(last_done - t0), 64'd7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
